// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive path.
//   rx_state_t    : bit-unstuffer state (ACTIVE, STUFF, ERR)
//   USB_STUFF_LEN : run of consecutive 1s after which a stuffed 0 follows
//   USB_BYTE_W    : assembled word width
package usb_rx_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    STUFF  = 2'd1,
    ERR    = 2'd2
  } rx_state_t;

  localparam int unsigned USB_STUFF_LEN = 6;
  localparam int unsigned USB_BYTE_W    = 8;

endpackage

// File: rtl/stuff_detector.sv
// Run-length tracker for USB bit stuffing.
// Counts consecutive 1s among data bits and keeps a flag marking that the
// next bit event carries a stuffed bit (which clears the run).
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset
//   bit_evt  : a non-EOP bit event to be tracked (data or stuffed bit)
//   b        : bit value for this event
//   eop      : end-of-packet event, clears the run
//   is_stuff : this data bit completes a run; the next bit is stuffed
module stuff_detector
  import usb_rx_pkg::*;
#(
  parameter int unsigned STUFF_LEN = USB_STUFF_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_evt,
  input  logic b,
  input  logic eop,
  output logic is_stuff
);

  localparam int unsigned OW = $clog2(STUFF_LEN + 1);
  localparam logic [OW-1:0] RUN_LAST = OW'(STUFF_LEN - 1);

  logic [OW-1:0] ones_cnt_q, ones_cnt_d;
  logic          pend_q, pend_d;

  always_comb begin
    ones_cnt_d = ones_cnt_q;
    pend_d     = pend_q;
    is_stuff   = 1'b0;
    if (eop) begin
      ones_cnt_d = '0;
      pend_d     = 1'b0;
    end else if (bit_evt) begin
      if (pend_q) begin
        // Stuffed bit: consumed here, restarts the run whatever its value.
        ones_cnt_d = '0;
        pend_d     = 1'b0;
      end else if (b) begin
        ones_cnt_d = ones_cnt_q + OW'(1);
        if (ones_cnt_q == RUN_LAST) begin
          pend_d   = 1'b1;
          is_stuff = 1'b1;
        end
      end else begin
        ones_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_cnt_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      ones_cnt_q <= ones_cnt_d;
      pend_q     <= pend_d;
    end
  end

endmodule

// File: rtl/rx_unstuff_shift.sv
// USB receive bit unstuffer and LSB-first byte assembler.
// Sits after the NRZI decoder; strobes are delayed one cycle to line up
// with the decoder's registered output bit.
// Optional macro RX_STUFF_ERR_CHECK_EN: a 1 in a stuffed-bit slot raises
// stuff_err and parks the block in ERR until EOP; otherwise the stuffed
// bit is dropped regardless of value and stuff_err stays 0.
// Ports:
//   clk          : system clock
//   rst          : synchronous active-high reset
//   d_orig       : decoded serial bit (valid one cycle after shift_enable)
//   shift_enable : bit strobe
//   eop          : end-of-packet flag, same timing as shift_enable
//   rx_byte      : last completed byte, held until the next one
//   byte_valid   : one-cycle pulse when rx_byte updates
//   stuff_err    : one-cycle pulse on bit-stuff violation
//   partial_err  : one-cycle pulse when EOP finds a partially filled byte
module rx_unstuff_shift
  import usb_rx_pkg::*;
#(
  parameter int unsigned DATA_W    = USB_BYTE_W,
  parameter int unsigned STUFF_LEN = USB_STUFF_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_orig,
  input  logic              shift_enable,
  input  logic              eop,
  output logic [DATA_W-1:0] rx_byte,
  output logic              byte_valid,
  output logic              stuff_err,
  output logic              partial_err
);

  localparam int unsigned BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  rx_state_t         state_q, state_d;
  logic              se_dly_q, se_dly_d;
  logic              eop_dly_q, eop_dly_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] rx_byte_q, rx_byte_d;
  logic              byte_valid_q, byte_valid_d;
  logic              stuff_err_q, stuff_err_d;
  logic              partial_err_q, partial_err_d;

  logic bit_evt;
  logic eop_evt;
  logic det_evt;
  logic is_stuff;

  assign bit_evt = se_dly_q & ~eop_dly_q;
  assign eop_evt = se_dly_q & eop_dly_q;
  // ERR ignores data entirely, so the run tracker must not see those bits.
  assign det_evt = bit_evt & (state_q != ERR);

  stuff_detector #(
    .STUFF_LEN(STUFF_LEN)
  ) u_stuff_detector (
    .clk     (clk),
    .rst     (rst),
    .bit_evt (det_evt),
    .b       (d_orig),
    .eop     (eop_evt),
    .is_stuff(is_stuff)
  );

  always_comb begin
    se_dly_d      = shift_enable;
    eop_dly_d     = eop;
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    rx_byte_d     = rx_byte_q;
    byte_valid_d  = 1'b0;
    stuff_err_d   = 1'b0;
    partial_err_d = 1'b0;

    if (eop_evt) begin
      partial_err_d = (bit_cnt_q != '0);
      bit_cnt_d     = '0;
      shreg_d       = '0;
      state_d       = ACTIVE;
    end else if (bit_evt) begin
      case (state_q)
        ACTIVE: begin
          shreg_d = {d_orig, shreg_q[DATA_W-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d    = '0;
            rx_byte_d    = {d_orig, shreg_q[DATA_W-1:1]};
            byte_valid_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
          // May coincide with byte completion; both take effect.
          if (is_stuff) begin
            state_d = STUFF;
          end
        end
        STUFF: begin
`ifdef RX_STUFF_ERR_CHECK_EN
          if (d_orig) begin
            stuff_err_d = 1'b1;
            bit_cnt_d   = '0;
            shreg_d     = '0;
            state_d     = ERR;
          end else begin
            state_d = ACTIVE;
          end
`else
          state_d = ACTIVE;
`endif
        end
        ERR: begin
          state_d = ERR;
        end
        default: begin
          state_d = ACTIVE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ACTIVE;
      se_dly_q      <= 1'b0;
      eop_dly_q     <= 1'b0;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      rx_byte_q     <= '0;
      byte_valid_q  <= 1'b0;
      stuff_err_q   <= 1'b0;
      partial_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      se_dly_q      <= se_dly_d;
      eop_dly_q     <= eop_dly_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      rx_byte_q     <= rx_byte_d;
      byte_valid_q  <= byte_valid_d;
      stuff_err_q   <= stuff_err_d;
      partial_err_q <= partial_err_d;
    end
  end

  assign rx_byte     = rx_byte_q;
  assign byte_valid  = byte_valid_q;
  assign stuff_err   = stuff_err_q;
  assign partial_err = partial_err_q;

endmodule

// File: tb/tb_rx_unstuff_shift.sv
// Self-checking bench for rx_unstuff_shift: table of hand-computed vectors,
// hand-written corner sequences and randomized strobes against a packet-level
// reference model of USB bit unstuffing.
module tb_rx_unstuff_shift;

  logic       clk = 1'b0;
  logic       rst;
  logic       d_orig;
  logic       shift_enable;
  logic       eop;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       stuff_err;
  logic       partial_err;

  rx_unstuff_shift #(
    .DATA_W   (8),
    .STUFF_LEN(6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .d_orig      (d_orig),
    .shift_enable(shift_enable),
    .eop         (eop),
    .rx_byte     (rx_byte),
    .byte_valid  (byte_valid),
    .stuff_err   (stuff_err),
    .partial_err (partial_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: run of 1s, pending stuffed slot, error lock, byte fill.
  int       m_run, m_nbits;
  bit       m_skip, m_err;
  bit [7:0] m_acc, m_last;
  bit       e_bv, e_se, e_pe;

  int n_bv = 0;
  int n_se = 0;

  typedef struct packed {
    bit       b;
    bit       e;
    bit       bv;
    bit [7:0] rb;
    bit       pe;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_nbits = 0; m_skip = 0; m_err = 0; m_acc = '0; m_last = '0;
  endtask

  task automatic model_step(input bit b, input bit e);
    e_bv = 0; e_se = 0; e_pe = 0;
    if (e) begin
      e_pe = (m_nbits != 0);
      m_run = 0; m_nbits = 0; m_skip = 0; m_err = 0; m_acc = '0;
    end else if (m_err) begin
      // locked until EOP
    end else if (m_skip) begin
      m_skip = 0;
      m_run  = 0;
`ifdef RX_STUFF_ERR_CHECK_EN
      if (b) begin
        e_se = 1; m_err = 1; m_nbits = 0; m_acc = '0;
      end
`endif
    end else begin
      m_acc[m_nbits] = b;
      m_nbits++;
      m_run = b ? m_run + 1 : 0;
      if (m_run == 6) m_skip = 1;
      if (m_nbits == 8) begin
        m_last = m_acc; e_bv = 1; m_nbits = 0; m_acc = '0;
      end
    end
  endtask

  // One strobe: se/eop for one cycle, bit presented the following cycle,
  // outputs sampled on the negedge after the processing edge.
  task automatic strobe(input bit b, input bit e,
                        output bit bv, output bit [7:0] rb, output bit pe, output bit se);
    @(negedge clk);
    shift_enable = 1'b1; eop = e; d_orig = 1'($urandom);
    @(negedge clk);
    chk("idle_pulses", {29'd0, byte_valid, stuff_err, partial_err}, 32'd0);
    shift_enable = 1'b0; eop = 1'b0; d_orig = b;
    @(negedge clk);
    bv = byte_valid; rb = rx_byte; pe = partial_err; se = stuff_err;
    n_bv += int'(byte_valid);
    n_se += int'(stuff_err);
    d_orig = 1'($urandom);
  endtask

  task automatic send(input bit b, input bit e);
    bit bv, pe, se;
    bit [7:0] rb;
    model_step(b, e);
    strobe(b, e, bv, rb, pe, se);
    chk("byte_valid", {31'd0, bv}, {31'd0, e_bv});
    chk("rx_byte", {24'd0, rb}, {24'd0, m_last});
    chk("stuff_err", {31'd0, se}, {31'd0, e_se});
    chk("partial_err", {31'd0, pe}, {31'd0, e_pe});
  endtask

  task automatic send_byte(input bit [7:0] v);
    for (int i = 0; i < 8; i++) send(v[i], 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; shift_enable = 1'b0; eop = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
    chk("rst_pulses", {29'd0, byte_valid, stuff_err, partial_err}, 32'd0);
    model_reset();
  endtask

  task automatic add(input bit b, input bit e, input bit bv, input bit [7:0] rb, input bit pe);
    vec_t v;
    v.b = b; v.e = e; v.bv = bv; v.rb = rb; v.pe = pe;
    tbl.push_back(v);
  endtask

  initial begin
    int bv0, se0;
    rst = 1'b1; shift_enable = 1'b0; eop = 1'b0; d_orig = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("init_rx_byte", {24'd0, rx_byte}, 32'd0);
    chk("init_pulses", {29'd0, byte_valid, stuff_err, partial_err}, 32'd0);

    // Stuff removal: 1x6, stuffed 0, 0, 0 -> 0x3F
    for (int i = 0; i < 6; i++) add(1, 0, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 0);
    add(0, 0, 1, 8'h3F, 0);
    add(0, 1, 0, 8'h3F, 0);          // EOP on a byte boundary
    for (int i = 0; i < 7; i++) add(0, 0, 0, 8'h3F, 0);
    add(0, 0, 1, 8'h00, 0);          // 0x00
    for (int i = 0; i < 6; i++) add(1, 0, 0, 8'h00, 0);
    add(0, 0, 0, 8'h00, 0);          // stuffed 0 inside 0xFF
    add(1, 0, 0, 8'h00, 0);
    add(1, 0, 1, 8'hFF, 0);          // 0xFF
    add(0, 1, 0, 8'hFF, 0);          // EOP on a byte boundary
    add(1, 0, 0, 8'hFF, 0);
    add(0, 0, 0, 8'hFF, 0);
    add(1, 0, 0, 8'hFF, 0);
    add(0, 1, 0, 8'hFF, 1);          // EOP after 3 bits
    add(0, 1, 0, 8'hFF, 0);          // back-to-back EOP, nothing pending

    for (int i = 0; i < tbl.size(); i++) begin
      bit bv, pe, se;
      bit [7:0] rb;
      model_step(tbl[i].b, tbl[i].e);
      strobe(tbl[i].b, tbl[i].e, bv, rb, pe, se);
      chk($sformatf("tbl%0d_bv", i), {31'd0, bv}, {31'd0, tbl[i].bv});
      chk($sformatf("tbl%0d_rb", i), {24'd0, rb}, {24'd0, tbl[i].rb});
      chk($sformatf("tbl%0d_pe", i), {31'd0, pe}, {31'd0, tbl[i].pe});
      chk($sformatf("tbl%0d_se", i), {31'd0, se}, 32'd0);
    end

    // Stuff violation: six 1s, a 1 in the stuffed slot, 8 more bits.
    bv0 = n_bv; se0 = n_se;
    for (int i = 0; i < 6; i++) send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send_byte(8'h12);
`ifdef RX_STUFF_ERR_CHECK_EN
    chk("viol_stuff_err_cnt", n_se - se0, 32'd1);
    chk("viol_byte_valid_cnt", n_bv - bv0, 32'd0);
`else
    chk("viol_stuff_err_cnt", n_se - se0, 32'd0);
    chk("viol_byte_valid_cnt", n_bv - bv0, 32'd1);
    chk("viol_dropped_byte", {24'd0, rx_byte}, 32'hBF);
`endif
    send(1'b0, 1'b1);
    bv0 = n_bv;
    send_byte(8'h12);
    chk("after_eop_byte", {24'd0, rx_byte}, 32'h12);
    chk("after_eop_bv_cnt", n_bv - bv0, 32'd1);
    send(1'b0, 1'b1);

    // Randomized packets, biased toward 1s to exercise stuffing.
    for (int i = 0; i < 400; i++) begin
      bit e, b;
      e = ($urandom_range(0, 24) == 0);
      b = ($urandom_range(0, 3) != 0);
      send(b, e);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("gap_pulses", {29'd0, byte_valid, stuff_err, partial_err}, 32'd0);
      end
    end

    // Reset mid-byte, then 0xA5.
    send(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send(1'($urandom), 1'b0);
    do_reset();
    bv0 = n_bv;
    send_byte(8'hA5);
    chk("post_rst_byte", {24'd0, rx_byte}, 32'hA5);
    chk("post_rst_bv_cnt", n_bv - bv0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
